// File: rtl/sram_init_ctrl.sv
// sram_init_ctrl: single-port SRAM with a request/grant/valid handshake, a
// read latency of 1 or 2 cycles, optional sideband (user) bits, and a clear
// sequencer that writes INIT_VALUE to every word after reset or on request.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset; restarts the clear sweep
//   init_req_i   starts a clear sweep when READY (priority over req_i)
//   init_done_o  high when READY, low while sweeping
//   req_i        access request, held by the client until granted
//   gnt_o        access accepted this cycle (combinational)
//   we_i         1 = write, 0 = read
//   addr_i       word address; addresses >= NUM_WORDS are granted but inert
//   wdata_i      write data
//   wuser_i      write sideband
//   be_i         byte enables; the last byte may be partial
//   rvalid_o     single-cycle read data valid strobe
//   rdata_o      read data, holds its last delivered value
//   ruser_o      read sideband, holds its last delivered value
module sram_init_ctrl #(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           USER_WIDTH = 1,
  parameter int unsigned           USER_EN    = 0,
  parameter int unsigned           NUM_WORDS  = 1024,
  parameter int unsigned           OUT_REGS   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int unsigned          ADDR_WIDTH = $clog2(NUM_WORDS),
  localparam int unsigned          BE_WIDTH   = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  init_req_i,
  output logic                  init_done_o,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [USER_WIDTH-1:0] wuser_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [USER_WIDTH-1:0] ruser_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH + 1)'(NUM_WORDS);

  typedef enum logic {
    INIT,
    READY
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  sweep_we;
  logic                  addr_ok;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] bit_en;

  logic                  rvalid_s1;
  logic [DATA_WIDTH-1:0] rdata_s1;
  logic [USER_WIDTH-1:0] ruser_s1;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. A sweep writes one word per cycle and cannot be
  // restarted by init_req_i, only by reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        if (cnt_q == LAST_WORD) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      READY: begin
        if (init_req_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. A clear request wins over a same-cycle access request.
  // ---------------------------------------------------------------------------
  always_comb begin
    init_done_o = (state_q == READY);
    sweep_we    = (state_q == INIT);
    gnt_o       = req_i & (state_q == READY) & ~init_req_i;
  end

  // Out-of-range addresses only occur for non-power-of-two depths.
  assign addr_ok = ({1'b0, addr_i} < DEPTH);
  assign wr_en   = gnt_o & we_i & addr_ok & ~rst_i;
  assign rd_en   = gnt_o & ~we_i;

  // Expand byte enables to bit enables; the top byte may be narrower than 8.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit_en
    assign bit_en[i] = be_i[i / 8];
  end

  // ---------------------------------------------------------------------------
  // Data array
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  // NOTE: the array has no reset branch; its contents are defined by the clear
  // sweep, and a reset on it would prevent block-RAM inference.
  always_ff @(posedge clk_i) begin
    if (!rst_i && sweep_we) begin
      mem[cnt_q] <= INIT_VALUE;
    end else if (wr_en) begin
      mem[addr_i] <= (mem[addr_i] & ~bit_en) | (wdata_i & bit_en);
    end
  end

  // Read stage 1: data as stored before this cycle's edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_s1 <= 1'b0;
      rdata_s1  <= '0;
    end else begin
      rvalid_s1 <= rd_en;
      if (rd_en) begin
        rdata_s1 <= addr_ok ? mem[addr_i] : '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional sideband array, written whenever any byte of the word is written.
  // ---------------------------------------------------------------------------
  if (USER_EN != 0) begin : g_user
    logic [USER_WIDTH-1:0] umem [NUM_WORDS];

    always_ff @(posedge clk_i) begin
      if (!rst_i && sweep_we) begin
        umem[cnt_q] <= '0;
      end else if (wr_en && (|be_i)) begin
        umem[addr_i] <= wuser_i;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ruser_s1 <= '0;
      end else if (rd_en) begin
        ruser_s1 <= addr_ok ? umem[addr_i] : '0;
      end
    end
  end else begin : g_no_user
    logic unused_wuser;
    assign unused_wuser = ^wuser_i;
    assign ruser_s1     = '0;
  end

  // ---------------------------------------------------------------------------
  // Optional second read stage. Data registers load only on a valid read so
  // the outputs hold their last delivered value.
  // ---------------------------------------------------------------------------
  if (OUT_REGS != 0) begin : g_out_reg
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rvalid_o <= 1'b0;
        rdata_o  <= '0;
        ruser_o  <= '0;
      end else begin
        rvalid_o <= rvalid_s1;
        if (rvalid_s1) begin
          rdata_o <= rdata_s1;
          ruser_o <= ruser_s1;
        end
      end
    end
  end else begin : g_out_direct
    assign rvalid_o = rvalid_s1;
    assign rdata_o  = rdata_s1;
    assign ruser_o  = ruser_s1;
  end

endmodule

// File: doc/sram_init_ctrl.md
# sram_init_ctrl

Parametrised single-port SRAM macro with a request/grant/valid handshake, selectable read latency, optional user (sideband) bits, and a built-in clear sequencer. The sequencer sweeps every word to INIT_VALUE after reset or on demand. It is the next-generation FPGA memory cut used by cache and scratchpad wrappers, for clients that need known-clean contents and an explicit read-valid strobe instead of a fixed-latency assumption.

## Interface
- DATA_WIDTH, 64: data word width in bits; byte enables are (DATA_WIDTH+7)/8 wide.
- USER_WIDTH, 1: sideband width per word.
- USER_EN, 0: 1 = user array implemented; 0 = no user storage, ruser_o tied to 0.
- NUM_WORDS, 1024: depth; any value ≥ 2, not required to be a power of two.
- OUT_REGS, 0: 0 = read latency 1; 1 = extra output register, read latency 2.
- INIT_VALUE, '0: DATA_WIDTH-bit value written to every word during a clear sweep; user bits are cleared to 0.
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- init_req_i  in  1  pulse; starts a clear sweep when the block is READY.
- init_done_o  out  1  high when READY, low during a sweep.
- req_i  in  1  access request.
- gnt_o  out  1  access accepted this cycle.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  $clog2(NUM_WORDS)  word address.
- wdata_i  in  DATA_WIDTH  write data.
- wuser_i  in  USER_WIDTH  write sideband.
- be_i  in  (DATA_WIDTH+7)/8  byte enables; the last byte may be partial.
- rvalid_o  out  1  read data valid.
- rdata_o  out  DATA_WIDTH  read data.
- ruser_o  out  USER_WIDTH  read sideband.

## Operation
- FSM states:
  - INIT: sweep counter cnt walks 0..NUM_WORDS-1, writing INIT_VALUE to data and 0 to user at word cnt, one word per cycle. After word NUM_WORDS-1 is written, the FSM moves to READY.
  - READY: serves requests.
- Reset enters INIT with cnt = 0. A reset mid-sweep restarts the sweep from word 0.
- READY plus init_req_i: next state is INIT with cnt = 0. gnt_o is 0 in that cycle, since init has priority over req_i.
- init_req_i in INIT is ignored; the sweep is not restarted.
- gnt_o = req_i & READY & !init_req_i, combinational. An ungranted request has no effect; the client holds the request until granted.
- Granted write: for each byte b with be_i[b] = 1, the byte is written from wdata_i. The user word is written from wuser_i when we_i & |be_i. be_i = 0 writes nothing.
- Granted read: returns the data and user word as stored before any write in the same cycle. A single port means no same-cycle write is possible.
- Address ≥ NUM_WORDS (non-power-of-two depth):
  - The request is still granted.
  - A write is dropped.
  - A read returns rdata_o = 0 and ruser_o = 0 with rvalid_o asserted normally.
- Read pipeline:
  - Valid flag plus data, one stage per latency cycle.
  - Reads granted before an init_req_i still complete and deliver data during INIT.
- rdata_o/ruser_o hold their last delivered value while rvalid_o = 0.
- USER_EN = 0: no user storage is inferred; wuser_i is ignored.

## Timing
- Reset values: gnt_o 0, init_done_o 0, rvalid_o 0, rdata_o 0, ruser_o 0, read pipeline valid flags 0. Memory contents are undefined until the sweep completes.
- Sweep timing, with cycle 0 = first edge where rst_i = 0:
  - Word k is written at cycle k.
  - init_done_o = 1 and gnt_o may assert from cycle NUM_WORDS.
- Runtime clear, with init_req_i sampled at cycle T:
  - init_done_o falls at T+1.
  - Word k is written at T+1+k.
  - READY again at T+1+NUM_WORDS.
- Read granted at cycle N: rvalid_o, rdata_o and ruser_o are valid at N+1 (OUT_REGS=0) or N+2 (OUT_REGS=1). rvalid_o is a single-cycle pulse.
- Throughput is one granted access per cycle, with back-to-back reads and writes in any mix.
- A write at cycle N is visible to a read granted at N+1.
- A synchronous reset at any cycle clears all in-flight read valids; no rvalid_o follows.

## Test plan
- Reset, then hold req_i = 1 from cycle 0; NUM_WORDS = 16, INIT_VALUE = 64'hA5A5_A5A5_A5A5_A5A5:
  - gnt_o is first 1 at cycle 16.
  - Reads of all 16 words return A5A5… with ruser_o = 0.
- Write 64'h0123_4567_89AB_CDEF to address 3 with be_i = 8'b0000_1111, then read address 3:
  - rdata_o = 64'hA5A5_A5A5_89AB_CDEF.
  - rvalid_o at N+1 (OUT_REGS=0) and at N+2 (OUT_REGS=1).
- Back-to-back write address 5 = 64'h55 then read address 5 on the next cycle:
  - rdata_o = 64'h55 one cycle later.
  - rvalid_o is a single pulse.
- NUM_WORDS = 12, read address 13:
  - gnt_o = 1.
  - rvalid_o = 1 with rdata_o = 0.
  - A write to address 13 leaves all 12 words unchanged.
- Read granted at T, then init_req_i at T+1 with req_i held:
  - Read data is delivered at T+2 (OUT_REGS=1).
  - gnt_o stays 0 until T+2+NUM_WORDS.
  - Previously written data reads back as INIT_VALUE.
- Assert rst_i mid-sweep at cnt = 7 and with one read in flight:
  - No rvalid_o follows.
  - The sweep restarts from word 0.
  - init_done_o rises exactly NUM_WORDS cycles after rst_i falls.
